// File: rtl/sdram_pkg.sv
// sdram_pkg: constants and command codes shared by the SDRAM write cache and the write stage
// Contents: DATA_W (word width), BURST_LEN (beats per write burst), sdram_cmd_t (RAS/CAS/WE/CS command codes)
package sdram_pkg;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 4;
    typedef enum logic [3:0] {
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVE    = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_NOP       = 4'b0111
    } sdram_cmd_t;
endpackage

// File: rtl/sdram_wr_ram.sv
// sdram_wr_ram: DEPTH x DATA_W storage, synchronous write port and asynchronous read port
// Ports: clk (write clock), we/waddr/wdata (write port), raddr/rdata (combinational read port)
// The array is deliberately not reset.
module sdram_wr_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/sdram_write_cache.sv
// sdram_write_cache: show-ahead circular FIFO buffering user writes into BURST_LEN-word SDRAM write bursts
// Ports: sysclk_100M (clock), rst (async active-high reset),
//        user_wr_en/user_wr_data/user_full (user push side),
//        beat_en/write_ready/wr_dq/wr_dq_oe (write-stage side).
// Optional: define WR_CACHE_ERR_EN to add sticky err_overflow/err_underflow flags and their err_clr input.
module sdram_write_cache #(
    parameter int DATA_W    = sdram_pkg::DATA_W,
    parameter int DEPTH     = 64,
    parameter int BURST_LEN = sdram_pkg::BURST_LEN
) (
    input  logic              sysclk_100M,
    input  logic              rst,
    input  logic              user_wr_en,
    input  logic [DATA_W-1:0] user_wr_data,
    output logic              user_full,
    input  logic              beat_en,
    output logic              write_ready,
    output logic [DATA_W-1:0] wr_dq,
    output logic              wr_dq_oe
`ifdef WR_CACHE_ERR_EN
   ,output logic              err_overflow,
    output logic              err_underflow,
    input  logic              err_clr
`endif
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   BL   = (AW+1)'(BURST_LEN);
    localparam logic [1:0]    LAST = 2'(BURST_LEN-1);

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, unclaimed, unclaimed_nxt;
    logic [1:0]        beat;
    logic [DATA_W-1:0] rdata;
    logic              push, pop, claim;

    sdram_wr_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk(sysclk_100M), .we(push), .waddr(wr_ptr), .wdata(user_wr_data),
        .raddr(rd_ptr), .rdata(rdata)
    );

    // A full cache still accepts a push when a pop frees a slot in the same cycle.
    // The first beat of each burst claims BURST_LEN words, so write_ready already
    // looks at the following burst while the current one is still streaming.
    always_comb begin
        pop           = beat_en && count != '0;
        push          = user_wr_en && (count != FULL || pop);
        claim         = beat_en && beat == 2'd0;
        unclaimed_nxt = (!claim ? unclaimed : unclaimed >= BL ? unclaimed - BL : '0) + (AW+1)'(push);
    end

    assign user_full   = count == FULL;
    assign write_ready = unclaimed >= BL;
    assign wr_dq       = pop ? rdata : '0;
    assign wr_dq_oe    = beat_en;

    always_ff @(posedge sysclk_100M or posedge rst)
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            unclaimed <= '0;
            beat      <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            unclaimed <= unclaimed_nxt;
            beat      <= !beat_en || beat == LAST ? 2'd0 : beat + 2'd1;
        end

`ifdef WR_CACHE_ERR_EN
    always_ff @(posedge sysclk_100M or posedge rst)
        if (rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= (user_wr_en && !push) || (err_overflow && !err_clr);
            err_underflow <= (beat_en && !pop) || (err_underflow && !err_clr);
        end
`endif
endmodule

// File: tb/tb_sdram_write_cache.sv
// tb_sdram_write_cache: self-checking bench for sdram_write_cache (vector table, corner sequences, random vs queue model)
module tb_sdram_write_cache;
    localparam int DW = 16;
    localparam int DEPTH = 64;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          user_wr_en = 1'b0;
    logic [DW-1:0] user_wr_data = '0;
    logic          beat_en = 1'b0;
    logic          user_full, write_ready, wr_dq_oe;
    logic [DW-1:0] wr_dq;
`ifdef WR_CACHE_ERR_EN
    logic          err_overflow, err_underflow;
    logic          err_clr = 1'b0;
`endif

    sdram_write_cache #(.DATA_W(DW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .sysclk_100M(clk), .rst(rst), .user_wr_en(user_wr_en), .user_wr_data(user_wr_data),
        .user_full(user_full), .beat_en(beat_en), .write_ready(write_ready),
        .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe)
`ifdef WR_CACHE_ERR_EN
       ,.err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the cache is a word queue; bursts claim BURST_LEN words
    // on their first beat, and the beat position counts consecutive beat_en cycles.
    logic [DW-1:0] q[$];
    int unc = 0;
    int mbeat = 0;

    typedef struct {
        logic          we;
        logic [DW-1:0] d;
        logic          be;
        logic          full;
        logic          ready;
        logic [DW-1:0] dq;
        logic          oe;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        unc = 0;
        mbeat = 0;
    endtask

    task automatic drive(input logic we, input logic [DW-1:0] d, input logic be);
        @(negedge clk);
        user_wr_en = we;
        user_wr_data = d;
        beat_en = be;
        #1;
    endtask

    // Compare outputs against the model for the current cycle, then advance it across the edge.
    task automatic advance();
        logic do_pop, do_push, do_claim;
        logic [DW-1:0] e;
        do_pop = beat_en && q.size() > 0;
        do_push = user_wr_en && (q.size() < DEPTH || do_pop);
        do_claim = beat_en && mbeat == 0;
        e = do_pop ? q[0] : '0;
        chk("m_full", user_full, q.size() == DEPTH);
        chk("m_ready", write_ready, unc >= BL);
        chk("m_dq", wr_dq, e);
        chk("m_oe", wr_dq_oe, beat_en);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(user_wr_data);
        if (do_claim) unc = unc >= BL ? unc - BL : 0;
        unc += do_push ? 1 : 0;
        mbeat = beat_en ? (mbeat + 1) % BL : 0;
        @(posedge clk);
    endtask

    task automatic cyc(input logic we, input logic [DW-1:0] d, input logic be);
        drive(we, d, be);
        advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        user_wr_en = 1'b0;
        beat_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1, 16'h0001, 0, 0, 0, 16'h0000, 0};
        vt[1]  = '{1, 16'h0002, 0, 0, 0, 16'h0000, 0};
        vt[2]  = '{1, 16'h0003, 0, 0, 0, 16'h0000, 0};
        vt[3]  = '{1, 16'h0004, 0, 0, 0, 16'h0000, 0};
        vt[4]  = '{0, 16'h0000, 0, 0, 1, 16'h0000, 0};
        vt[5]  = '{0, 16'h0000, 1, 0, 1, 16'h0001, 1};
        vt[6]  = '{0, 16'h0000, 1, 0, 0, 16'h0002, 1};
        vt[7]  = '{0, 16'h0000, 1, 0, 0, 16'h0003, 1};
        vt[8]  = '{0, 16'h0000, 1, 0, 0, 16'h0004, 1};
        vt[9]  = '{0, 16'h0000, 1, 0, 0, 16'h0000, 1};
        vt[10] = '{0, 16'h0000, 0, 0, 0, 16'h0000, 0};

        // Reset state, including wr_dq_oe following beat_en while rst is high.
        #2;
        chk("rst_full", user_full, 0);
        chk("rst_ready", write_ready, 0);
        chk("rst_dq", wr_dq, 0);
        chk("rst_oe", wr_dq_oe, 0);
        beat_en = 1'b1;
        #1;
        chk("rst_oe_be", wr_dq_oe, 1);
        chk("rst_dq_be", wr_dq, 0);
        beat_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Push 4 words, one 4-beat burst, then an underflow beat.
        foreach (vt[i]) begin
            drive(vt[i].we, vt[i].d, vt[i].be);
            chk($sformatf("vec%0d_full", i), user_full, vt[i].full);
            chk($sformatf("vec%0d_ready", i), write_ready, vt[i].ready);
            chk($sformatf("vec%0d_dq", i), wr_dq, vt[i].dq);
            chk($sformatf("vec%0d_oe", i), wr_dq_oe, vt[i].oe);
            advance();
        end

        // 8 words stored: write_ready stays high through the whole first burst.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, DW'(16'h0100 + i), 0);
        for (int i = 0; i < BL; i++) begin
            drive(0, 0, 1);
            chk($sformatf("b8_ready%0d", i), write_ready, 1);
            chk($sformatf("b8_dq%0d", i), wr_dq, 16'h0100 + i);
            advance();
        end
        cyc(0, 0, 0);
        for (int i = 0; i < BL; i++) begin
            drive(0, 0, 1);
            chk($sformatf("b8_rest%0d", i), wr_dq, 16'h0104 + i);
            advance();
        end
        drive(0, 0, 1);
        chk("b8_empty", wr_dq, 0);
        advance();
        cyc(0, 0, 0);

        // Fill to DEPTH, drop a word while full, accept one during a pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, DW'(16'h1000 + i), 0);
        drive(1, 16'hDEAD, 0);
        chk("full_at_depth", user_full, 1);
        advance();
        drive(1, 16'hBEEF, 1);
        chk("full_before_beef", user_full, 1);
        chk("dq_first", wr_dq, 16'h1000);
        advance();
        drive(0, 0, 0);
        chk("full_after_beef", user_full, 1);
`ifdef WR_CACHE_ERR_EN
        chk("err_overflow", err_overflow, 1);
`endif
        advance();
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 1);
        chk("drained", q.size(), 0);
        cyc(0, 0, 0);

        // 70 pushes while bursting continuously: pointer wrap and ordering.
        do_reset();
        for (int i = 0; i < 70; i++) cyc(1, DW'(16'h2000 + i), 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);

        // Reset asserted during beat 2 of a burst.
        for (int i = 0; i < 8; i++) cyc(1, DW'(16'h3000 + i), 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        drive(0, 0, 1);
        chk("mid_dq", wr_dq, 16'h3002);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", write_ready, 0);
        chk("mid_rst_full", user_full, 0);
        chk("mid_rst_dq", wr_dq, 0);
        chk("mid_rst_oe", wr_dq_oe, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        beat_en = 1'b0;
        for (int i = 0; i < BL; i++) begin
            drive(1, DW'(16'h4000 + i), 0);
            chk($sformatf("post_rst_ready%0d", i), write_ready, 0);
            advance();
        end
        drive(0, 0, 0);
        chk("post_rst_ready4", write_ready, 1);
        advance();
        for (int i = 0; i < BL; i++) begin
            drive(0, 0, 1);
            chk($sformatf("post_rst_dq%0d", i), wr_dq, 16'h4000 + i);
            advance();
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 45));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end
endmodule
